// File: rtl/fsk_pic_scan_dec.sv
// fsk_pic_scan_dec
//   Per-channel peak detectors feeding one shared, sequenced binary-to-BCD
//   converter. A scan snapshots every peak, converts the channels one after
//   another by double-dabble and writes each result into a BCD result bank.
//
// Parameters
//   NCH      number of measurement channels (2..8)
//   W        input / peak width, unsigned bits (4..16)
//   ND       BCD digits per result (2..5)
//   DECAY_SH 0 = pure peak hold; k>0 = a lower sample decays pk by pk>>k
//
// Ports
//   clk       system clock, rising edge
//   st        synchronous active-high reset
//   ce        sample strobe; peaks update only when high
//   a_in      packed amplitudes, channel i at [i*W +: W]
//   clr_pk    clear all peak registers (wins over ce)
//   scan_req  start a scan of all channels (ignored while busy)
//   rd_sel    channel select for the read outputs
//   rd_dec    BCD result of channel rd_sel (0 when rd_sel >= NCH)
//   rd_pk     live peak of channel rd_sel (0 when rd_sel >= NCH)
//   ovf       per channel: last converted value exceeded 10^ND-1
//   busy      scan in progress
//   done      one-cycle pulse once the result bank is fully updated
module fsk_pic_scan_dec #(
  parameter int NCH      = 4,
  parameter int W        = 12,
  parameter int ND       = 4,
  parameter int DECAY_SH = 0
) (
  input  logic                     clk,
  input  logic                     st,
  input  logic                     ce,
  input  logic [NCH*W-1:0]         a_in,
  input  logic                     clr_pk,
  input  logic                     scan_req,
  input  logic [$clog2(NCH)-1:0]   rd_sel,
  output logic [4*ND-1:0]          rd_dec,
  output logic [W-1:0]             rd_pk,
  output logic [NCH-1:0]           ovf,
  output logic                     busy,
  output logic                     done
);

  localparam int SW = $clog2(NCH);
  localparam int CW = $clog2(W);

  // Largest value that fits in ND decimal digits.
  localparam logic [31:0] MAXV = 32'(10 ** ND - 1);

  function automatic logic [4*ND-1:0] all_nines();
    logic [4*ND-1:0] r;
    r = '0;
    for (int d = 0; d < ND; d++) r[4*d +: 4] = 4'd9;
    return r;
  endfunction

  localparam logic [4*ND-1:0] ALL9 = all_nines();

  // Double-dabble correction: every digit of 5 or more gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [4*ND-1:0] add3(input logic [4*ND-1:0] v);
    logic [4*ND-1:0] r;
    r = v;
    for (int d = 0; d < ND; d++) begin
      if (v[4*d +: 4] >= 4'd5) r[4*d +: 4] = v[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

  logic [W-1:0]    a    [NCH];
  logic [W-1:0]    pk   [NCH];
  logic [W-1:0]    snap [NCH];
  logic [4*ND-1:0] res  [NCH];

  state_t          state;
  logic [SW-1:0]   ch;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    bin;
  logic [4*ND-1:0] bcd;
  logic [4*ND-1:0] bcd_adj;
  logic            done_pend;

  // Unpack the amplitude bus into one word per channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) a[i] = a_in[i*W +: W];
  end

  // Peak detectors. Clear beats sample; a lower sample either holds the peak
  // or, with decay enabled, removes a fraction of it. pk - (pk>>k) can never
  // go below zero, and stalls once pk < 2^k.
  always_ff @(posedge clk) begin
    if (st || clr_pk) begin
      for (int i = 0; i < NCH; i++) pk[i] <= '0;
    end else if (ce) begin
      for (int i = 0; i < NCH; i++) begin
        if (a[i] >= pk[i]) pk[i] <= a[i];
        else if (DECAY_SH > 0) pk[i] <= pk[i] - (pk[i] >> DECAY_SH);
      end
    end
  end

  always_comb bcd_adj = add3(bcd);

  // Scan sequencer. The snapshot taken on acceptance decouples the
  // conversion from live peak activity. done is delayed one extra cycle
  // through done_pend, so it rises the cycle after busy falls.
  always_ff @(posedge clk) begin
    if (st) begin
      state     <= IDLE;
      ch        <= '0;
      cnt       <= '0;
      bin       <= '0;
      bcd       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_pend <= 1'b0;
      ovf       <= '0;
      for (int i = 0; i < NCH; i++) begin
        res[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      done      <= done_pend;
      done_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_req) begin
            for (int i = 0; i < NCH; i++) snap[i] <= pk[i];
            ch    <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          bin   <= snap[ch];
          bcd   <= '0;
          cnt   <= CW'(W - 1);
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt - 1'b1;
          if (cnt == '0) state <= STORE;
        end
        STORE: begin
          if ({{(32-W){1'b0}}, snap[ch]} > MAXV) begin
            res[ch] <= ALL9;
            ovf[ch] <= 1'b1;
          end else begin
            res[ch] <= bcd;
            ovf[ch] <= 1'b0;
          end
          if (ch == SW'(NCH - 1)) begin
            busy      <= 1'b0;
            done_pend <= 1'b1;
            state     <= IDLE;
          end else begin
            ch    <= ch + 1'b1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read mux; out-of-range selects read as zero.
  always_comb begin
    rd_dec = '0;
    rd_pk  = '0;
    if ({1'b0, rd_sel} < (SW+1)'(NCH)) begin
      rd_dec = res[rd_sel];
      rd_pk  = pk[rd_sel];
    end
  end

endmodule

// File: tb/tb_fsk_pic_scan_dec.sv
// tb_fsk_pic_scan_dec
//   Self-checking bench for fsk_pic_scan_dec. Three instances share the
//   stimulus: the default build, an ND=3 build and a DECAY_SH=2 build.
//   A timeline model of the default build runs on every clock edge.
module tb_fsk_pic_scan_dec;

  localparam int NCH  = 4;
  localparam int W    = 12;
  localparam int ND   = 4;
  localparam int STEP = W + 2;
  localparam int SCAN = NCH * STEP;
  localparam int MAXV = 10 ** ND - 1;

  logic             clk = 1'b0;
  logic             st, ce, clr_pk, scan_req;
  logic [NCH*W-1:0] a_in;
  logic [1:0]       rd_sel;

  logic [15:0] rd_dec;  logic [11:0] rd_pk;  logic [3:0] ovf;  logic busy,  done;
  logic [11:0] rd_dec3; logic [11:0] rd_pk3; logic [3:0] ovf3; logic busy3, done3;
  logic [15:0] rd_decd; logic [11:0] rd_pkd; logic [3:0] ovfd; logic busyd, doned;

  int n_cmp = 0;
  int n_err = 0;

  // Model state for the default instance.
  int m_pk [NCH];
  int m_snap [NCH];
  int m_res [NCH];
  bit m_ovf [NCH];
  bit m_busy, m_done, m_dpend;
  int m_t;

  typedef struct {
    logic ce;
    logic clr;
    int   a0;
    int   pk;
    int   pkd;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  fsk_pic_scan_dec #(.NCH(4), .W(12), .ND(4), .DECAY_SH(0)) dut (
    .clk(clk), .st(st), .ce(ce), .a_in(a_in), .clr_pk(clr_pk), .scan_req(scan_req),
    .rd_sel(rd_sel), .rd_dec(rd_dec), .rd_pk(rd_pk), .ovf(ovf), .busy(busy), .done(done));

  fsk_pic_scan_dec #(.NCH(4), .W(12), .ND(3), .DECAY_SH(0)) dut_nd3 (
    .clk(clk), .st(st), .ce(ce), .a_in(a_in), .clr_pk(clr_pk), .scan_req(scan_req),
    .rd_sel(rd_sel), .rd_dec(rd_dec3), .rd_pk(rd_pk3), .ovf(ovf3), .busy(busy3), .done(done3));

  fsk_pic_scan_dec #(.NCH(4), .W(12), .ND(4), .DECAY_SH(2)) dut_dec (
    .clk(clk), .st(st), .ce(ce), .a_in(a_in), .clr_pk(clr_pk), .scan_req(scan_req),
    .rd_sel(rd_sel), .rd_dec(rd_decd), .rd_pk(rd_pkd), .ovf(ovfd), .busy(busyd), .done(doned));

  // Decimal digits of v packed as BCD nibbles.
  function automatic int to_bcd(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r = r | ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setA(input int v0, input int v1, input int v2, input int v3);
    a_in = {W'(v3), W'(v2), W'(v1), W'(v0)};
  endtask

  // Advance one clock edge with the inputs currently driven, moving the model
  // along the scan timeline: accepted at t=0, channel c stored at
  // t=(c+1)*STEP, busy drops at t=SCAN, done pulses one edge later.
  task automatic applyStimulus();
    int av [NCH];
    int c;
    for (int i = 0; i < NCH; i++) av[i] = int'(a_in[i*W +: W]);
    if (st) begin
      for (int i = 0; i < NCH; i++) begin
        m_pk[i] = 0; m_snap[i] = 0; m_res[i] = 0; m_ovf[i] = 1'b0;
      end
      m_busy = 1'b0; m_done = 1'b0; m_dpend = 1'b0; m_t = 0;
    end else begin
      m_done  = m_dpend;
      m_dpend = 1'b0;
      if (!m_busy) begin
        if (scan_req) begin
          for (int i = 0; i < NCH; i++) m_snap[i] = m_pk[i];
          m_busy = 1'b1;
          m_t    = 0;
        end
      end else begin
        m_t++;
        if (m_t % STEP == 0) begin
          c        = m_t / STEP - 1;
          m_res[c] = (m_snap[c] > MAXV) ? MAXV : m_snap[c];
          m_ovf[c] = (m_snap[c] > MAXV);
        end
        if (m_t == SCAN) begin
          m_busy  = 1'b0;
          m_dpend = 1'b1;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (clr_pk) m_pk[i] = 0;
        else if (ce && av[i] >= m_pk[i]) m_pk[i] = av[i];
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Run until done is seen, returning edges counted after the accepting edge.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      applyStimulus();
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic loadPeaks(input int v0, input int v1, input int v2, input int v3);
    clr_pk = 1'b1;
    applyStimulus();
    clr_pk = 1'b0;
    ce = 1'b1;
    setA(v0, v1, v2, v3);
    applyStimulus();
    ce = 1'b0;
  endtask

  task automatic startScan();
    scan_req = 1'b1;
    applyStimulus();
    scan_req = 1'b0;
  endtask

  initial begin
    int lat;
    int v;
    int n_done;
    int exp2 [4];
    int exp5 [4];
    int mov;

    tbl[0] = '{1'b1, 1'b0, 200,  200,  200};
    tbl[1] = '{1'b1, 1'b0, 150,  200,  150};
    tbl[2] = '{1'b0, 1'b0, 999,  200,  150};
    tbl[3] = '{1'b1, 1'b1, 77,   0,    0};
    tbl[4] = '{1'b1, 1'b0, 77,   77,   77};
    tbl[5] = '{1'b0, 1'b1, 5,    0,    0};
    tbl[6] = '{1'b1, 1'b0, 4095, 4095, 4095};
    tbl[7] = '{1'b1, 1'b0, 0,    4095, 3072};
    tbl[8] = '{1'b1, 1'b0, 0,    4095, 2304};

    exp2[0] = 'h4095; exp2[1] = 'h0000; exp2[2] = 'h1000; exp2[3] = 'h0009;
    exp5[0] = 'h0123; exp5[1] = 'h4000; exp5[2] = 'h0056; exp5[3] = 'h0007;

    st = 1'b1; ce = 1'b0; clr_pk = 1'b0; scan_req = 1'b0; a_in = '0; rd_sel = '0;
    repeat (3) applyStimulus();
    st = 1'b0;
    applyStimulus();

    $display("[TB] reset state");
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_ovf", int'(ovf), 0);
    for (int s = 0; s < NCH; s++) begin
      rd_sel = 2'(s);
      #1;
      checkOutput("rst_rd_dec", int'(rd_dec), 0);
      checkOutput("rst_rd_pk", int'(rd_pk), 0);
    end

    $display("[TB] peak table");
    rd_sel = 2'd0;
    for (int i = 0; i < 9; i++) begin
      ce = tbl[i].ce;
      clr_pk = tbl[i].clr;
      setA(tbl[i].a0, 0, 0, 0);
      applyStimulus();
      checkOutput($sformatf("tbl%0d_pk", i), int'(rd_pk), tbl[i].pk);
      checkOutput($sformatf("tbl%0d_pkd", i), int'(rd_pkd), tbl[i].pkd);
    end
    clr_pk = 1'b0;

    // Decay toward zero with a=0; stalls once pk < 2^DECAY_SH.
    v = 2304;
    ce = 1'b1;
    setA(0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      v = v - (v >> 2);
    end
    ce = 1'b0;
    checkOutput("decay_floor", int'(rd_pkd), v);
    checkOutput("hold_no_decay", int'(rd_pk), 4095);

    $display("[TB] scan latency and results");
    loadPeaks(4095, 0, 1000, 9);
    startScan();
    checkOutput("scan_busy_after_req", int'(busy), 1);
    waitDone(lat);
    checkOutput("done_latency", lat, SCAN + 1);
    checkOutput("busy_at_done", int'(busy), 0);
    for (int s = 0; s < NCH; s++) begin
      rd_sel = 2'(s);
      #1;
      checkOutput($sformatf("scan_ch%0d", s), int'(rd_dec), exp2[s]);
    end
    checkOutput("scan_ovf", int'(ovf), 0);

    $display("[TB] scan_req on done cycle");
    startScan();
    waitDone(lat);
    scan_req = 1'b1;
    applyStimulus();
    scan_req = 1'b0;
    checkOutput("rescan_busy", int'(busy), 1);
    checkOutput("rescan_done_low", int'(done), 0);
    waitDone(lat);
    checkOutput("rescan_latency", lat, SCAN + 1);

    $display("[TB] ND=3 overflow");
    loadPeaks(4095, 999, 0, 0);
    startScan();
    waitDone(lat);
    checkOutput("nd3_done", int'(done3), 1);
    rd_sel = 2'd0;
    #1;
    checkOutput("nd3_ch0_dec", int'(rd_dec3), 'h999);
    checkOutput("nd3_ch0_ovf", int'(ovf3[0]), 1);
    checkOutput("nd4_ch0_dec", int'(rd_dec), 'h4095);
    rd_sel = 2'd1;
    #1;
    checkOutput("nd3_ch1_dec", int'(rd_dec3), 'h999);
    checkOutput("nd3_ch1_ovf", int'(ovf3[1]), 0);

    $display("[TB] requests and clear during scan");
    loadPeaks(123, 4000, 56, 7);
    startScan();
    n_done = 0;
    for (int k = 0; k < 150; k++) begin
      scan_req = (k == 20 || k == 40);
      clr_pk = (k == 30);
      applyStimulus();
      if (done) n_done++;
    end
    scan_req = 1'b0;
    clr_pk = 1'b0;
    checkOutput("single_done", n_done, 1);
    for (int s = 0; s < NCH; s++) begin
      rd_sel = 2'(s);
      #1;
      checkOutput($sformatf("snap_ch%0d", s), int'(rd_dec), exp5[s]);
      checkOutput($sformatf("cleared_pk%0d", s), int'(rd_pk), 0);
    end

    $display("[TB] reset mid-scan");
    loadPeaks(4095, 999, 500, 1);
    startScan();
    waitDone(lat);
    startScan();
    repeat (20) applyStimulus();
    st = 1'b1;
    repeat (3) applyStimulus();
    st = 1'b0;
    n_done = 0;
    for (int k = 0; k < 70; k++) begin
      applyStimulus();
      if (done || done3 || doned) n_done++;
    end
    checkOutput("mid_rst_no_done", n_done, 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_busy_other", int'(busy3 | busyd), 0);
    checkOutput("mid_rst_ovf", int'(ovf), 0);
    checkOutput("mid_rst_ovf3", int'(ovf3), 0);
    checkOutput("mid_rst_ovfd", int'(ovfd), 0);
    for (int s = 0; s < NCH; s++) begin
      rd_sel = 2'(s);
      #1;
      checkOutput("mid_rst_dec", int'(rd_dec), 0);
      checkOutput("mid_rst_dec3", int'(rd_dec3), 0);
      checkOutput("mid_rst_decd", int'(rd_decd), 0);
      checkOutput("mid_rst_pk", int'(rd_pk | rd_pk3 | rd_pkd), 0);
    end

    $display("[TB] randomized run against model");
    for (int k = 0; k < 2500; k++) begin
      st       = ($urandom_range(0, 599) == 0);
      ce       = 1'($urandom_range(0, 1));
      clr_pk   = ($urandom_range(0, 29) == 0);
      scan_req = ($urandom_range(0, 9) == 0);
      setA($urandom_range(0, 4095), $urandom_range(0, 4095),
           $urandom_range(0, 4095), $urandom_range(0, 4095));
      rd_sel   = 2'($urandom_range(0, 3));
      applyStimulus();
      mov = 0;
      for (int i = 0; i < NCH; i++) mov = mov | (int'(m_ovf[i]) << i);
      checkOutput("rand_busy", int'(busy), int'(m_busy));
      checkOutput("rand_done", int'(done), int'(m_done));
      checkOutput("rand_ovf", int'(ovf), mov);
      checkOutput("rand_rd_pk", int'(rd_pk), m_pk[rd_sel]);
      checkOutput("rand_rd_dec", int'(rd_dec), to_bcd(m_res[rd_sel]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
